// File: rtl/prog_loader_if.sv
// prog_loader_if: host command, instruction-memory, core-control, register-file and dump signals.
interface prog_loader_if #(parameter int IMEM_AW = 10);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_data;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               core_rst_n;
  logic               core_run;
  logic               core_halted;
  logic [4:0]         rf_raddr;
  logic [31:0]        rf_rdata;
  logic               dump_valid;
  logic               dump_ready;
  logic [31:0]        dump_data;
  logic               busy;
  logic               timeout;
  logic               done;
  modport master (
    input  cmd_valid, cmd_data, core_halted, rf_rdata, dump_ready,
    output cmd_ready, imem_we, imem_addr, imem_wdata, core_rst_n, core_run,
           rf_raddr, dump_valid, dump_data, busy, timeout, done
  );
  modport slave (
    output cmd_valid, cmd_data, core_halted, rf_rdata, dump_ready,
    input  cmd_ready, imem_we, imem_addr, imem_wdata, core_rst_n, core_run,
           rf_raddr, dump_valid, dump_data, busy, timeout, done
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a program into instruction memory, runs the core until halt or timeout,
// then streams the core's register file out one word at a time.
module prog_loader #(
  parameter int IMEM_AW    = 10,
  parameter int NREGS      = 32,
  parameter int RUN_CYCLES = 256
) (
  input logic           clk,
  input logic           rst_n,
  prog_loader_if.master bus
);
  localparam int CW = $clog2(RUN_CYCLES + 1);
  localparam logic [31:0] NMAX = 32'(1) << IMEM_AW;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_RD, DUMP_TX, DONE} state_t;
  state_t state, nxt;
  logic [IMEM_AW:0] n, k;
  logic [CW-1:0] cnt;
  logic [4:0] i;
  logic cmd_hs, run_end, last_k, last_i;
  assign cmd_hs     = bus.cmd_valid && bus.cmd_ready;
  assign run_end    = cnt == CW'(RUN_CYCLES - 1);
  assign last_k     = k + 1'b1 == n;
  assign last_i     = i == 5'(NREGS - 1);
  assign bus.cmd_ready  = state == IDLE || state == LOAD;
  assign bus.core_rst_n = !(state == IDLE || state == LOAD);
  assign bus.core_run   = state == RUN;
  assign bus.dump_valid = state == DUMP_TX;
  assign bus.busy       = state != IDLE;
  assign bus.done       = state == DONE;
  assign bus.rf_raddr   = i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cmd_hs) nxt = bus.cmd_data != 0 ? LOAD : RUN;
      LOAD:    if (cmd_hs && last_k) nxt = RUN;
      RUN:     if (bus.core_halted || run_end) nxt = DUMP_RD;
      DUMP_RD: nxt = DUMP_TX;
      DUMP_TX: if (bus.dump_ready) nxt = last_i ? DONE : DUMP_RD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n              <= '0;
      k              <= '0;
      cnt            <= '0;
      i              <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.dump_data  <= '0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.imem_we <= state == LOAD && cmd_hs;
      cnt         <= state == RUN ? cnt + 1'b1 : '0;
      if (state == IDLE && cmd_hs) begin
        n           <= bus.cmd_data > NMAX ? (IMEM_AW+1)'(NMAX) : bus.cmd_data[IMEM_AW:0];
        k           <= '0;
        bus.timeout <= 1'b0;
      end
      if (state == LOAD && cmd_hs) begin
        bus.imem_addr  <= k[IMEM_AW-1:0];
        bus.imem_wdata <= bus.cmd_data;
        k              <= k + 1'b1;
      end
      // a halt on the final run cycle takes priority over the timeout
      if (state == RUN && !bus.core_halted && run_end) bus.timeout <= 1'b1;
      if (state == RUN) i <= '0;
      if (state == DUMP_RD) bus.dump_data <= bus.rf_rdata;
      if (state == DUMP_TX && bus.dump_ready && !last_i) i <= i + 1'b1;
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized load/run/dump sequences checked against a queue-based reference model.
module tb_prog_loader;
  localparam int AW = 10, NR = 32, RC = 256, NEVER = 1 << 30;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  prog_loader_if #(.IMEM_AW(AW)) bus();
  prog_loader #(.IMEM_AW(AW), .NREGS(NR), .RUN_CYCLES(RC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] prog [8] = '{32'h00a00093, 32'h01400113, 32'h01900193, 32'h00208233,
                            32'h003202b3, 32'h00526333, 32'h00000393, 32'h005273b3};
  logic [31:0] rf [NR];
  int halt_at = NEVER, run_cnt = 0, bp_mode = 0, stall = 0, run_len = 0, done_cnt = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], dump_q[$];
  logic held = 1'b0;
  logic [31:0] held_data;

  // core model: counts enabled cycles since its reset and raises HALTED at halt_at
  assign bus.rf_rdata    = rf[bus.rf_raddr];
  assign bus.core_halted = bus.core_run && run_cnt >= halt_at;
  always @(posedge clk) run_cnt <= !bus.core_rst_n ? 0 : run_cnt + (bus.core_run ? 1 : 0);

  always @(posedge clk) begin
    #1;
    if (bp_mode == 2 && bus.dump_valid && bus.rf_raddr == 5'd4 && stall < 5) begin
      bus.dump_ready = 1'b0;
      stall++;
    end else bus.dump_ready = bp_mode == 1 ? $urandom_range(0, 2) != 0 : 1'b1;
  end

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr_q.push_back(32'(bus.imem_addr));
      wr_data_q.push_back(bus.imem_wdata);
    end
    if (bus.core_run) run_len++;
    if (bus.done) done_cnt++;
    if (held) begin
      check("hold_valid", 32'(bus.dump_valid), 1);
      check("hold_data", bus.dump_data, held_data);
    end
    if (bus.dump_valid && bus.dump_ready) dump_q.push_back(bus.dump_data);
    held = bus.dump_valid && !bus.dump_ready;
    held_data = bus.dump_data;
  end

  task automatic send(input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_data = $urandom;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_data = w;
    while (!bus.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bus.cmd_data = $urandom;
  endtask

  task automatic run_prog(input logic [31:0] count, input int halt, input int bp, input bit use_prog);
    int n, t, exp_len;
    logic [31:0] words[$];
    n = count > 1024 ? 1024 : int'(count);
    exp_len = halt < RC ? halt + 1 : RC;
    halt_at = halt;
    bp_mode = bp;
    stall = 0;
    for (int j = 0; j < NR; j++) rf[j] = j == 0 ? 32'd0 : $urandom;
    wr_addr_q.delete();
    wr_data_q.delete();
    dump_q.delete();
    run_len = 0;
    done_cnt = 0;
    send(count);
    check("busy_after_count", 32'(bus.busy), 1);
    check("timeout_cleared", 32'(bus.timeout), 0);
    for (int j = 0; j < n; j++) begin
      words.push_back(use_prog && j < 8 ? prog[j] : $urandom);
      send(words[j]);
    end
    t = 0;
    while (!bus.done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(bus.done), 1);
    @(negedge clk);
    @(negedge clk);
    check("imem_writes", wr_addr_q.size(), n);
    for (int j = 0; j < wr_addr_q.size() && j < n; j++) begin
      check("imem_addr", wr_addr_q[j], j);
      check("imem_data", wr_data_q[j], words[j]);
    end
    check("run_len", run_len, exp_len);
    check("timeout", 32'(bus.timeout), 32'(halt >= RC));
    check("dump_count", dump_q.size(), NR);
    for (int j = 0; j < dump_q.size() && j < NR; j++) check("dump_word", dump_q[j], rf[j]);
    check("done_pulses", done_cnt, 1);
    check("busy_idle", 32'(bus.busy), 0);
    if (bp == 2) check("stall_cycles", stall, 5);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_imem_we", 32'(bus.imem_we), 0);
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_core_rst_n", 32'(bus.core_rst_n), 0);
    check("rst_core_run", 32'(bus.core_run), 0);
    check("rst_rf_raddr", 32'(bus.rf_raddr), 0);
    check("rst_dump_valid", 32'(bus.dump_valid), 0);
    check("rst_dump_data", bus.dump_data, 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    check("rst_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    run_prog(8, 20, 0, 1);
    run_prog(8, 20, 2, 1);
    run_prog(5, NEVER, 1, 0);
    run_prog(0, 255, 0, 0);
    run_prog(32'h7FF, 3, 1, 0);
    repeat (3) run_prog($urandom_range(1, 40), $urandom_range(0, 300), 1, 0);
    // abort a load part-way through with an asynchronous reset
    send(8);
    repeat (3) send($urandom);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("mid_rst_core_rst_n", 32'(bus.core_rst_n), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_imem_we", 32'(bus.imem_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_prog(8, 20, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
